// File: rtl/jtag_vector_seq.sv
// jtag_vector_seq: plays a RAM-stored TMS/TDI/ADC vector list onto JTAG and captures TDO per vector
module jtag_vector_seq #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] vector_start,
    input  logic [ADDR_W-1:0] vector_end,
    input  logic [31:0]       vector_number_repeat,
    input  logic [31:0]       tck_width,
    output logic [ADDR_W-1:0] vector_1_addr,
    input  logic [7:0]        vector_1_rd_data,
    output logic [ADDR_W-1:0] vector_2_addr,
    output logic              vector_2_we,
    output logic [7:0]        vector_2_wr_data,
    input  logic              tdo,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    output logic              adc_start,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, LOW, HIGH, NEXT} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] a1_q, a1_d, a2_q, a2_d, beg_q, beg_d, end_q, end_d;
    logic [31:0] rep_q, rep_d, h_q, h_d, cnt_q, cnt_d;
    logic tms_q, tms_d, tdi_q, tdi_d, adc_bit_q, adc_bit_d, tck_q, tck_d;
    logic we_q, we_d, adc_q, adc_d, done_q, done_d;
    logic [7:0] wd_q, wd_d;
    logic unused_bits;
    assign unused_bits = ^vector_1_rd_data[7:3];
    always_comb begin
        state_d = state_q;
        a1_d = a1_q;
        a2_d = a2_q;
        beg_d = beg_q;
        end_d = end_q;
        rep_d = rep_q;
        h_d = h_q;
        cnt_d = cnt_q;
        tms_d = tms_q;
        tdi_d = tdi_q;
        adc_bit_d = adc_bit_q;
        wd_d = wd_q;
        we_d = 1'b0;
        adc_d = 1'b0;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                beg_d = vector_start;
                end_d = vector_end;
                a1_d = vector_start;
                a2_d = '0;
                rep_d = (vector_number_repeat == 32'd0) ? 32'd1 : vector_number_repeat;
                h_d = (tck_width == 32'd0) ? 32'd1 : tck_width;
                state_d = FETCH;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                tms_d = vector_1_rd_data[0];
                tdi_d = vector_1_rd_data[1];
                adc_bit_d = vector_1_rd_data[2];
                cnt_d = 32'd0;
                state_d = LOW;
            end
            LOW: if (cnt_q == h_q - 32'd1) begin
                cnt_d = 32'd0;
                we_d = 1'b1;
                wd_d = {5'b0, adc_bit_q, tdi_q, tdo};
                adc_d = adc_bit_q;
                state_d = HIGH;
            end else cnt_d = cnt_q + 32'd1;
            HIGH: if (cnt_q == h_q - 32'd1) state_d = NEXT;
                  else cnt_d = cnt_q + 32'd1;
            NEXT: begin
                a2_d = a2_q + 1'b1;
                if (a1_q != end_q) begin
                    a1_d = a1_q + 1'b1;
                    state_d = FETCH;
                end else if (rep_q > 32'd1) begin
                    rep_d = rep_q - 32'd1;
                    a1_d = beg_q;
                    state_d = FETCH;
                end else begin
                    done_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            we_d = 1'b0;
            adc_d = 1'b0;
            done_d = 1'b0;
        end
        tck_d = (state_d == HIGH);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a1_q <= '0;
            a2_q <= '0;
            beg_q <= '0;
            end_q <= '0;
            rep_q <= '0;
            h_q <= '0;
            cnt_q <= '0;
            tms_q <= 1'b0;
            tdi_q <= 1'b0;
            adc_bit_q <= 1'b0;
            tck_q <= 1'b0;
            we_q <= 1'b0;
            wd_q <= '0;
            adc_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a1_q <= a1_d;
            a2_q <= a2_d;
            beg_q <= beg_d;
            end_q <= end_d;
            rep_q <= rep_d;
            h_q <= h_d;
            cnt_q <= cnt_d;
            tms_q <= tms_d;
            tdi_q <= tdi_d;
            adc_bit_q <= adc_bit_d;
            tck_q <= tck_d;
            we_q <= we_d;
            wd_q <= wd_d;
            adc_q <= adc_d;
            done_q <= done_d;
        end
    end
    assign vector_1_addr = a1_q;
    assign vector_2_addr = a2_q;
    assign vector_2_we = we_q;
    assign vector_2_wr_data = wd_q;
    assign tck = tck_q;
    assign tms = tms_q;
    assign tdi = tdi_q;
    assign adc_start = adc_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
endmodule

// File: tb/tb_jtag_vector_seq.sv
// tb_jtag_vector_seq: table-driven runs with a capture scoreboard plus abort/reset corner sequences
`timescale 1ns/1ps
module tb_jtag_vector_seq;
    localparam int AW = 12;
    logic clk = 1'b0;
    logic reset, start, abort, tdo;
    logic [AW-1:0] vector_start, vector_end, vector_1_addr, vector_2_addr;
    logic [31:0] vector_number_repeat, tck_width;
    logic [7:0] vector_1_rd_data, vector_2_wr_data;
    logic vector_2_we, tck, tms, tdi, adc_start, busy, done;
    logic [7:0] mem [0:4095];

    jtag_vector_seq #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .vector_start(vector_start), .vector_end(vector_end),
        .vector_number_repeat(vector_number_repeat), .tck_width(tck_width),
        .vector_1_addr(vector_1_addr), .vector_1_rd_data(vector_1_rd_data),
        .vector_2_addr(vector_2_addr), .vector_2_we(vector_2_we),
        .vector_2_wr_data(vector_2_wr_data), .tdo(tdo), .tck(tck), .tms(tms),
        .tdi(tdi), .adc_start(adc_start), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) vector_1_rd_data <= mem[vector_1_addr];

    typedef struct packed {
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic          tms;
        logic [7:0]    wd;
    } cap_t;
    typedef struct {
        logic [AW-1:0] vs;
        logic [AW-1:0] ve;
        logic [31:0]   rep;
        logic [31:0]   tw;
        logic          tdo;
        int            cycles;
        int            h;
    } case_t;

    cap_t exp_q[$];
    cap_t e;
    case_t tbl[5];
    int tests = 0, fails = 0, hi_len = 0, exp_h = 1, adc_cnt = 0;
    bit chk_h = 1'b1, done_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (vector_2_we) begin
            if (exp_q.size() == 0) check("unexpected_capture", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("cap_vec1_addr", 32'(vector_1_addr), 32'(e.a1));
                check("cap_vec2_addr", 32'(vector_2_addr), 32'(e.a2));
                check("cap_tms", 32'(tms), 32'(e.tms));
                check("cap_data", 32'(vector_2_wr_data), 32'(e.wd));
            end
        end
        if (adc_start) begin
            adc_cnt++;
            check("adc_on_tck_rise", 32'({tck, vector_2_we}), 32'd3);
        end
        if (tck) hi_len++;
        else begin
            if (hi_len != 0 && chk_h) check("tck_high_len", hi_len, exp_h);
            hi_len = 0;
        end
        if (done) done_seen = 1'b1;
    end

    task automatic push_exp(input logic [AW-1:0] vs, input logic [AW-1:0] ve, input logic [31:0] rep,
                            input logic t, input int limit, output int adcs);
        logic [AW-1:0] a, a2;
        int passes, n;
        cap_t c;
        passes = (rep == 0) ? 1 : int'(rep);
        n = 0;
        adcs = 0;
        a2 = '0;
        for (int p = 0; p < passes; p++) begin
            a = vs;
            forever begin
                if (n < limit) begin
                    c.a1 = a;
                    c.a2 = a2;
                    c.tms = mem[a][0];
                    c.wd = {5'b0, mem[a][2], mem[a][1], t};
                    exp_q.push_back(c);
                    adcs += int'(mem[a][2]);
                end
                n++;
                a2 = a2 + 1'b1;
                if (a == ve) break;
                a = a + 1'b1;
            end
        end
    endtask

    task automatic configure(input logic [AW-1:0] vs, input logic [AW-1:0] ve, input logic [31:0] rep,
                             input logic [31:0] tw, input logic t);
        vector_start = vs;
        vector_end = ve;
        vector_number_repeat = rep;
        tck_width = tw;
        tdo = t;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_capture(input logic [AW-1:0] a2, input string name);
        int cyc = 0;
        while (!(vector_2_we && vector_2_addr == a2) && cyc < 300) begin
            @(posedge clk);
            #1 cyc++;
        end
        check(name, 32'(cyc < 300), 32'd1);
    endtask

    task automatic run_case(input case_t c);
        int adcs, cyc;
        configure(c.vs, c.ve, c.rep, c.tw, c.tdo);
        exp_h = c.h;
        chk_h = 1'b1;
        adc_cnt = 0;
        push_exp(c.vs, c.ve, c.rep, c.tdo, 1000, adcs);
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        configure(~c.vs, c.vs, 32'd9, 32'd7, c.tdo);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("done_latency", cyc, c.cycles);
        check("captures_left", exp_q.size(), 32'd0);
        check("adc_pulses", adc_cnt, adcs);
        @(posedge clk);
        #1 check("done_one_cycle", 32'({done, busy}), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int adcs;
        foreach (mem[i]) mem[i] = 8'h00;
        mem[12'h004] = 8'h01; mem[12'h005] = 8'h02; mem[12'h006] = 8'h03;
        mem[12'hFFE] = 8'h05; mem[12'hFFF] = 8'h02; mem[12'h000] = 8'h01; mem[12'h001] = 8'h06;
        mem[12'h010] = 8'h04; mem[12'h011] = 8'h02;
        mem[12'h020] = 8'h02;
        mem[12'h030] = 8'h01; mem[12'h031] = 8'h03; mem[12'h032] = 8'h07;
        mem[12'h040] = 8'h02; mem[12'h041] = 8'h01; mem[12'h042] = 8'h00; mem[12'h043] = 8'h03;
        tbl[0] = '{12'h004, 12'h006, 32'd1, 32'd2, 1'b0, 21, 2};
        tbl[1] = '{12'hFFE, 12'h001, 32'd2, 32'd1, 1'b0, 40, 1};
        tbl[2] = '{12'h010, 12'h011, 32'd0, 32'd0, 1'b0, 10, 1};
        tbl[3] = '{12'h020, 12'h020, 32'd3, 32'd1, 1'b1, 15, 1};
        tbl[4] = '{12'h020, 12'h020, 32'd1, 32'd3, 1'b0, 9, 3};
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        configure('0, '0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl_outs", 32'({tck, tms, tdi, vector_2_we, adc_start, busy, done}), 32'd0);
        check("reset_vec1_addr", 32'(vector_1_addr), 32'd0);
        check("reset_vec2_addr", 32'(vector_2_addr), 32'd0);
        check("reset_wr_data", 32'(vector_2_wr_data), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        foreach (tbl[i]) run_case(tbl[i]);

        configure(12'h030, 12'h032, 32'd1, 32'd2, 1'b1);
        chk_h = 1'b0;
        push_exp(12'h030, 12'h032, 32'd1, 1'b1, 2, adcs);
        abort = 1'b1;
        pulse_start();
        abort = 1'b0;
        check("start_beats_abort", 32'(busy), 32'd1);
        wait_capture(12'd1, "abort_reach_v2");
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy_tck", 32'({busy, tck}), 32'd0);
        done_seen = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_captures_left", exp_q.size(), 32'd0);
        exp_q.delete();

        configure(12'h040, 12'h043, 32'd1, 32'd3, 1'b0);
        exp_h = 3;
        chk_h = 1'b1;
        push_exp(12'h040, 12'h043, 32'd1, 1'b0, 2, adcs);
        pulse_start();
        repeat (3) @(posedge clk);
        #1 configure(12'h100, 12'h040, 32'd5, 32'd1, 1'b0);
        pulse_start();
        wait_capture(12'd1, "reset_reach_v2");
        repeat (7) @(posedge clk);
        #1 check("mid_low_v3", 32'({busy, tck, vector_1_addr}), 32'({1'b1, 1'b0, 12'h042}));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("midrun_reset_ctrl", 32'({tck, tms, tdi, vector_2_we, adc_start, busy, done}), 32'd0);
        check("midrun_reset_addrs", 32'({vector_1_addr, vector_2_addr}), 32'd0);
        check("midrun_reset_data", 32'(vector_2_wr_data), 32'd0);
        check("reset_captures_left", exp_q.size(), 32'd0);
        repeat (30) @(posedge clk);
        #1 check("stays_idle", 32'(busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
